// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: PC-1, PC-2, the per-round rotate
// schedule, fixed widths, the key-schedule FSM encoding and a rotate helper.
// Bit numbering follows the DES standard: bit 1 is the MSB.
package des_pkg;

    localparam int KEY_W  = 64;
    localparam int CD_W   = 28;
    localparam int RK_W   = 48;
    localparam int ROUNDS = 16;

    // PC-1: entries 0..27 build C, entries 28..55 build D (key bit numbers).
    localparam int PC1_TBL [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    // PC-2: selects 48 of the 56 {C,D} bits (numbers refer to {C,D}).
    localparam int PC2_TBL [0:47] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Left-rotate amount for rounds 1..16 (index 0 is round 1).
    localparam int SHIFT_TBL [0:15] = '{
        1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } ks_state_t;

    // Rotate a 28-bit half left by one or two places (bit 1 is the MSB).
    function automatic logic [1:CD_W] rot_left(input logic [1:CD_W] v,
                                               input logic        by_two);
        return by_two ? {v[3:CD_W], v[1:2]} : {v[2:CD_W], v[1]};
    endfunction

endpackage

// File: rtl/des_pc2_permutation.sv
// Combinational PC-2 permutation: 56-bit {C,D} in, 48-bit round key out.
// Pure wiring; the eight {C,D} bits PC-2 drops are folded into an unused net.
module des_pc2_permutation
    import des_pkg::*;
(
    input  logic [1:2*CD_W] cd,
    output logic [1:RK_W]   round_key
);

    for (genvar i = 0; i < RK_W; i++) begin : g_bit
        assign round_key[i+1] = cd[PC2_TBL[i]];
    end

    // Bits 9, 18, 22, 25, 35, 38, 43 and 54 never reach a round key.
    logic unused_dropped;
    assign unused_dropped = ^{cd[9], cd[18], cd[22], cd[25],
                              cd[35], cd[38], cd[43], cd[54]};

endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: PC-1 at load, then one rotate + PC-2 per cycle,
// filling the 16 round-key slots of round_keys over 16 cycles.
// Optional feature macro: DES_KEYSCHED_DECRYPT_EN adds a `decrypt` input that
// reverses slot order (round n lands in slot 17-n) for decryption.
module des_key_schedule
    import des_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:KEY_W]       key,
`ifdef DES_KEYSCHED_DECRYPT_EN
    input  logic                 decrypt,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [1:RK_W*ROUNDS] round_keys
);

    ks_state_t                 state;
    logic [3:0]                counter;
    logic [1:CD_W]             c_q;
    logic [1:CD_W]             d_q;
    logic [0:ROUNDS-1][1:RK_W] rk_slots;

    logic [1:2*CD_W]           key_pc1;
    logic                      two_step;
    logic [1:CD_W]             c_rot;
    logic [1:CD_W]             d_rot;
    logic [1:RK_W]             round_key;
    logic [3:0]                slot;

    // PC-1 applied straight to the input key; only used on the start edge.
    for (genvar i = 0; i < 2*CD_W; i++) begin : g_pc1
        assign key_pc1[i+1] = key[PC1_TBL[i]];
    end

    // Parity bits 8,16,...,64 are not part of the key material.
    logic unused_parity;
    assign unused_parity = ^{key[8], key[16], key[24], key[32],
                             key[40], key[48], key[56], key[64]};

    // Rotate for round counter+1; PC-2 sees the rotated value in the same cycle.
    assign two_step = (SHIFT_TBL[counter] == 2);
    assign c_rot    = rot_left(c_q, two_step);
    assign d_rot    = rot_left(d_q, two_step);

    des_pc2_permutation u_pc2 (
        .cd        ({c_rot, d_rot}),
        .round_key (round_key)
    );

`ifdef DES_KEYSCHED_DECRYPT_EN
    logic decrypt_q;
    assign slot = decrypt_q ? (4'd15 - counter) : counter;
`else
    assign slot = counter;
`endif

    // Key-schedule FSM: load on start, 16 round cycles, one-cycle DONE.
    always_ff @(posedge clk) begin
        // NOTE: every register here uses <= so all of them update from the
        // pre-edge values; a blocking = would let later lines see new values.
        if (!rst_n) begin
            state    <= ST_IDLE;
            counter  <= '0;
            c_q      <= '0;
            d_q      <= '0;
            // NOTE: the round-key store is reset because a mid-run abort must
            // leave round_keys at zero; it is small enough to be plain flops.
            rk_slots <= '0;
`ifdef DES_KEYSCHED_DECRYPT_EN
            decrypt_q <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        c_q      <= key_pc1[1:CD_W];
                        d_q      <= key_pc1[CD_W+1:2*CD_W];
                        counter  <= '0;
                        rk_slots <= '0;
`ifdef DES_KEYSCHED_DECRYPT_EN
                        decrypt_q <= decrypt;
`endif
                        state    <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    c_q            <= c_rot;
                    d_q            <= d_rot;
                    rk_slots[slot] <= round_key;
                    counter        <= counter + 4'd1;
                    if (counter == 4'd15) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Status is decoded from the state register only.
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);
    assign round_keys = rk_slots;

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule: scoreboard queue of expected
// round-key vectors filled at each accepted start, drained by a monitor that
// compares on every done pulse. The reference model builds each round key
// from cumulative rotation amounts rather than stepping registers.
module tb_des_key_schedule;

    localparam logic [1:64] KAT_KEY = 64'h133457799BBCDFF1;
    localparam logic [1:64] PARITY  = 64'h0101010101010101;

    localparam int PC1_REF [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_REF [0:47] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SH_REF [0:15] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:64]   key = '0;
`ifdef DES_KEYSCHED_DECRYPT_EN
    logic          decrypt = 1'b0;
`endif
    logic          busy;
    logic          done;
    logic [1:768]  round_keys;

    des_key_schedule dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .key        (key),
`ifdef DES_KEYSCHED_DECRYPT_EN
        .decrypt    (decrypt),
`endif
        .busy       (busy),
        .done       (done),
        .round_keys (round_keys)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [1:768] rk;
        int           due;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [1:768] act, input logic [1:768] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Round n uses the PC-1 halves rotated left by the sum of the first n shifts.
    function automatic logic [1:768] ref_schedule(input logic [1:64] k, input bit dec);
        logic [1:768] r;
        logic [1:28]  c0, d0;
        logic [1:56]  cd;
        int           s;
        int           slot;
        r = '0;
        s = 0;
        for (int i = 1; i <= 28; i++) begin
            c0[i] = k[PC1_REF[i-1]];
            d0[i] = k[PC1_REF[i+27]];
        end
        for (int n = 1; n <= 16; n++) begin
            s += SH_REF[n-1];
            for (int i = 1; i <= 28; i++) begin
                cd[i]      = c0[(i - 1 + s) % 28 + 1];
                cd[28 + i] = d0[(i - 1 + s) % 28 + 1];
            end
            slot = dec ? 17 - n : n;
            for (int j = 1; j <= 48; j++) r[48*(slot-1) + j] = cd[PC2_REF[j-1]];
        end
        return r;
    endfunction

    function automatic logic [1:64] rand_key();
        return {$urandom, $urandom};
    endfunction

    // Drive a one-cycle start; key is scrambled afterwards to prove it is not re-sampled.
    task automatic pulse_start(input logic [1:64] k, input bit dec);
        @(posedge clk); #1;
        start = 1'b1;
        key   = k;
`ifdef DES_KEYSCHED_DECRYPT_EN
        decrypt = dec;
`else
        if (dec) $display("decrypt request ignored in this build");
`endif
        @(posedge clk); #1;
        start = 1'b0;
        key   = rand_key();
    endtask

    // Accepted start: record the expected vector and the cycle done must appear in.
    task automatic start_run(input logic [1:64] k, input bit dec, input logic [1:768] exp_rk);
        @(posedge clk); #1;
        start = 1'b1;
        key   = k;
`ifdef DES_KEYSCHED_DECRYPT_EN
        decrypt = dec;
`else
        if (dec) $display("decrypt request ignored in this build");
`endif
        exp_q.push_back('{rk: exp_rk, due: cyc + 17});
        @(posedge clk); #1;
        start = 1'b0;
        key   = rand_key();
    endtask

    // Wait (bounded) for done; optionally require busy on every cycle before it.
    task automatic wait_done(input bit chk_busy);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (chk_busy) check("busy_during_run", busy, 1'b1);
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: done=0 after 40 cycles, required 1");
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: done=1 with no run pending, required 0");
                end else begin
                    e = exp_q.pop_front();
                    check("round_keys", round_keys, e.rk);
                    check("done_cycle", cyc, e.due);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [1:768] kat_rk;
        logic [1:64]  k;
        bit           dec;

        kat_rk = ref_schedule(KAT_KEY, 1'b0);

        // Reset values
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_round_keys", round_keys, '0);

        // Known-answer key
        start_run(KAT_KEY, 1'b0, kat_rk);
        wait_done(1'b1);
        check("kat_k1", round_keys[1:48], 48'h1B02EFFC7072);
        check("kat_k2", round_keys[49:96], 48'h79AED9DBC9E5);
        check("kat_k16", round_keys[721:768], 48'hCB3D8B0E17F5);
        repeat (3) @(negedge clk);
        check("hold_after_done", round_keys, kat_rk);
        check("idle_busy", busy, 1'b0);

        // Parity bits flipped: same schedule
        start_run(KAT_KEY ^ PARITY, 1'b0, kat_rk);
        wait_done(1'b0);

        // In-flight re-starts with another key are ignored
        k = rand_key();
        start_run(k, 1'b0, ref_schedule(k, 1'b0));
        fork
            begin
                @(posedge clk);
                pulse_start(rand_key(), 1'b0);
                repeat (11) @(posedge clk);
                pulse_start(rand_key(), 1'b0);
            end
            wait_done(1'b1);
        join
        repeat (2) @(negedge clk);
        check("no_restart_busy", busy, 1'b0);

        // Reset mid-run aborts with no done
        start_run(rand_key(), 1'b0, '0);
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("abort_round_keys", round_keys, '0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        repeat (25) @(negedge clk);
        check("abort_stays_idle", busy, 1'b0);

        // Start while reset is asserted: reset wins
        @(posedge clk); #1;
        rst_n = 1'b0;
        start = 1'b1;
        key   = rand_key();
        @(posedge clk); #1;
        rst_n = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_wins_busy", busy, 1'b0);

        // Fresh run after abort, then back-to-back start with an all-zero key
        k = rand_key();
        start_run(k, 1'b0, ref_schedule(k, 1'b0));
        wait_done(1'b1);
        start_run('0, 1'b0, '0);
        wait_done(1'b1);
        check("zero_key_slots", round_keys, '0);

`ifdef DES_KEYSCHED_DECRYPT_EN
        // Reversed slot order for decryption
        start_run(KAT_KEY, 1'b1, ref_schedule(KAT_KEY, 1'b1));
        wait_done(1'b0);
        check("dec_slot1", round_keys[1:48], 48'hCB3D8B0E17F5);
        check("dec_slot16", round_keys[721:768], 48'h1B02EFFC7072);
`endif

        // Random keys
        for (int r = 0; r < 8; r++) begin
            k = rand_key();
`ifdef DES_KEYSCHED_DECRYPT_EN
            dec = 1'($urandom_range(0, 1));
`else
            dec = 1'b0;
`endif
            start_run(k, dec, ref_schedule(k, dec));
            wait_done(1'b1);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
